// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM encoding, BCD limits
// and an integer-to-packed-BCD helper.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_MAX  = 8'h99;

    // Values above 99 wrap modulo 100; callers keep the argument in 0..99.
    function automatic logic [7:0] to_bcd(input int unsigned val);
        int unsigned tens;
        int unsigned ones;
        tens = (val / 10) % 10;
        ones = val % 10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed BCD register with load, saturating increment at 99 and
// flooring decrement at 00. Increment and decrement together hold the value.
module bcd2_counter
    import score_pkg::*;
#(
    parameter logic [7:0] RST_VAL = BCD_ZERO
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] value_o
);

    logic [7:0] value_q, value_d;
    logic [3:0] tens, ones;

    assign tens    = value_q[7:4];
    assign ones    = value_q[3:0];
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            if (value_q != BCD_MAX) begin
                if (ones == 4'd9) value_d = {tens + 4'd1, 4'd0};
                else              value_d = {tens, ones + 4'd1};
            end
        end else if (dec_i && !inc_i) begin
            if (value_q != BCD_ZERO) begin
                if (ones == 4'd0) value_d = {tens - 4'd1, 4'd9};
                else              value_d = {tens, ones - 4'd1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) value_q <= RST_VAL;
        else       value_q <= value_d;
    end

endmodule

// File: rtl/score_keeper.sv
// Timed game-round controller: BCD score, BCD countdown and session high
// score, all registered for the 7-segment display stage.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned ROUND_SECS    = 30
) (
    input  logic       clk_1k,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [7:0] score,
    output logic [7:0] time_left,
    output logic [7:0] high_score,
    output logic       playing,
    output logic       game_over,
    output logic       new_high
);

    localparam int unsigned    PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]     ROUND_BCD  = to_bcd(ROUND_SECS);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    high_q, high_d;
    logic          over_first_q, over_first_d;
    logic          new_high_q, new_high_d;
    logic          playing_q, playing_d;
    logic          game_over_q, game_over_d;

    logic round_go, in_play, wrap, timeout;

    assign in_play  = (state_q == ST_PLAY);
    assign round_go = start && !in_play;
    assign wrap     = in_play && (presc_q == PRESC_LAST);
    assign timeout  = wrap && (time_left == 8'h01);

    bcd2_counter #(
        .RST_VAL (BCD_ZERO)
    ) u_score (
        .clk_i      (clk_1k),
        .rst_i      (rst),
        .load_i     (round_go),
        .load_val_i (BCD_ZERO),
        .inc_i      (hit && in_play),
        .dec_i      (miss && in_play),
        .value_o    (score)
    );

    bcd2_counter #(
        .RST_VAL (ROUND_BCD)
    ) u_timer (
        .clk_i      (clk_1k),
        .rst_i      (rst),
        .load_i     (round_go),
        .load_val_i (ROUND_BCD),
        .inc_i      (1'b0),
        .dec_i      (wrap),
        .value_o    (time_left)
    );

    always_ff @(posedge clk_1k) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)   state_d = ST_PLAY;
            ST_PLAY: if (timeout) state_d = ST_OVER;
            ST_OVER: if (start)   state_d = ST_PLAY;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        playing_d    = (state_d == ST_PLAY);
        game_over_d  = (state_d == ST_OVER);
        over_first_d = (state_d == ST_OVER) && (state_q != ST_OVER);
        // Compare one cycle after entering OVER so a hit on the final edge counts.
        new_high_d   = over_first_q && (score > high_q);
        high_d       = new_high_d ? score : high_q;
        presc_d      = presc_q;
        if (round_go)     presc_d = '0;
        else if (wrap)    presc_d = '0;
        else if (in_play) presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk_1k) begin
        if (rst) begin
            presc_q      <= '0;
            high_q       <= BCD_ZERO;
            over_first_q <= 1'b0;
            new_high_q   <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            high_q       <= high_d;
            over_first_q <= over_first_d;
            new_high_q   <= new_high_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
        end
    end

    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a long-round instance for scoring and high
// score, and a short-round instance (4 ticks x 3 s) for the timer.
module tb_score_keeper;

    logic clk;
    logic rst;
    logic start_a, hit_a, miss_a;
    logic start_b, hit_b, miss_b;
    logic [7:0] score_a, time_a, high_a;
    logic [7:0] score_b, time_b, high_b;
    logic playing_a, game_over_a, new_high_a;
    logic playing_b, game_over_b, new_high_b;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    score_keeper #(
        .TICKS_PER_SEC (20),
        .ROUND_SECS    (30)
    ) dut_a (
        .clk_1k     (clk),
        .rst        (rst),
        .start      (start_a),
        .hit        (hit_a),
        .miss       (miss_a),
        .score      (score_a),
        .time_left  (time_a),
        .high_score (high_a),
        .playing    (playing_a),
        .game_over  (game_over_a),
        .new_high   (new_high_a)
    );

    score_keeper #(
        .TICKS_PER_SEC (4),
        .ROUND_SECS    (3)
    ) dut_b (
        .clk_1k     (clk),
        .rst        (rst),
        .start      (start_b),
        .hit        (hit_b),
        .miss       (miss_b),
        .score      (score_b),
        .time_left  (time_b),
        .high_score (high_b),
        .playing    (playing_b),
        .game_over  (game_over_b),
        .new_high   (new_high_b)
    );

    // One input cycle on dut_a; returns at the negedge after the applying edge.
    task automatic a_drive(input logic s, input logic h, input logic m);
        start_a = s; hit_a = h; miss_a = m;
        @(negedge clk);
        start_a = 1'b0; hit_a = 1'b0; miss_a = 1'b0;
    endtask

    task automatic a_hits(input int n);
        repeat (n) a_drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic a_misses(input int n);
        repeat (n) a_drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic a_wait_over(input string tag);
        int cyc;
        cyc = 0;
        while (game_over_a !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (game_over_a !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_round_end: game_over=%b expected=1 after %0d cycles", tag, game_over_a, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hit_a = 1'b1; hit_b = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; hit_a = 1'b0; hit_b = 1'b0;
        n_checks++; if (score_a !== 8'h00) begin n_fail++; $display("FAIL reset_score: got %h expected 00", score_a); end
        n_checks++; if (time_a !== 8'h30) begin n_fail++; $display("FAIL reset_time: got %h expected 30", time_a); end
        n_checks++; if (high_a !== 8'h00) begin n_fail++; $display("FAIL reset_high: got %h expected 00", high_a); end
        n_checks++; if (playing_a !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %b expected 0", playing_a); end
        n_checks++; if (game_over_a !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", game_over_a); end
        n_checks++; if (new_high_a !== 1'b0) begin n_fail++; $display("FAIL reset_new_high: got %b expected 0", new_high_a); end
        n_checks++; if (time_b !== 8'h03) begin n_fail++; $display("FAIL reset_time_b: got %h expected 03", time_b); end
    endtask

    task automatic test_count();
        a_drive(1'b1, 1'b0, 1'b0);
        n_checks++; if (playing_a !== 1'b1) begin n_fail++; $display("FAIL start_playing: got %b expected 1", playing_a); end
        n_checks++; if (time_a !== 8'h30) begin n_fail++; $display("FAIL start_time: got %h expected 30", time_a); end
        a_hits(9);
        n_checks++; if (score_a !== 8'h09) begin n_fail++; $display("FAIL count_09: got %h expected 09", score_a); end
        a_hits(1);
        n_checks++; if (score_a !== 8'h10) begin n_fail++; $display("FAIL carry_10: got %h expected 10", score_a); end
        a_hits(9);
        n_checks++; if (score_a !== 8'h19) begin n_fail++; $display("FAIL count_19: got %h expected 19", score_a); end
        a_hits(1);
        n_checks++; if (score_a !== 8'h20) begin n_fail++; $display("FAIL carry_20: got %h expected 20", score_a); end
        a_hits(3);
        n_checks++; if (score_a !== 8'h23) begin n_fail++; $display("FAIL count_23: got %h expected 23", score_a); end
        a_misses(4);
        n_checks++; if (score_a !== 8'h19) begin n_fail++; $display("FAIL borrow_19: got %h expected 19", score_a); end
    endtask

    task automatic test_saturate();
        a_hits(80);
        n_checks++; if (score_a !== 8'h99) begin n_fail++; $display("FAIL count_99: got %h expected 99", score_a); end
        a_hits(1);
        n_checks++; if (score_a !== 8'h99) begin n_fail++; $display("FAIL sat_99: got %h expected 99", score_a); end
        a_misses(99);
        n_checks++; if (score_a !== 8'h00) begin n_fail++; $display("FAIL down_00: got %h expected 00", score_a); end
        a_misses(1);
        n_checks++; if (score_a !== 8'h00) begin n_fail++; $display("FAIL floor_00: got %h expected 00", score_a); end
        a_hits(45);
        a_drive(1'b0, 1'b1, 1'b1);
        n_checks++; if (score_a !== 8'h45) begin n_fail++; $display("FAIL hit_miss_hold: got %h expected 45", score_a); end
        a_drive(1'b1, 1'b0, 1'b0);
        n_checks++; if (score_a !== 8'h45) begin n_fail++; $display("FAIL start_in_play: got %h expected 45", score_a); end
        a_misses(5);
        a_wait_over("sat");
        @(negedge clk);
        n_checks++; if (high_a !== 8'h40) begin n_fail++; $display("FAIL high_40: got %h expected 40", high_a); end
        n_checks++; if (new_high_a !== 1'b1) begin n_fail++; $display("FAIL pulse_40: got %b expected 1", new_high_a); end
    endtask

    task automatic test_mid_reset();
        a_drive(1'b1, 1'b0, 1'b0);
        a_hits(12);
        n_checks++; if (score_a !== 8'h12) begin n_fail++; $display("FAIL pre_reset_score: got %h expected 12", score_a); end
        rst = 1'b1; hit_a = 1'b1;
        @(negedge clk);
        rst = 1'b0; hit_a = 1'b0;
        n_checks++; if (score_a !== 8'h00) begin n_fail++; $display("FAIL mid_rst_score: got %h expected 00", score_a); end
        n_checks++; if (high_a !== 8'h00) begin n_fail++; $display("FAIL mid_rst_high: got %h expected 00", high_a); end
        n_checks++; if (time_a !== 8'h30) begin n_fail++; $display("FAIL mid_rst_time: got %h expected 30", time_a); end
        n_checks++; if (playing_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_playing: got %b expected 0", playing_a); end
        a_hits(1);
        n_checks++; if (score_a !== 8'h00) begin n_fail++; $display("FAIL idle_hit: got %h expected 00", score_a); end
    endtask

    task automatic test_high_score();
        int         hits  [4] = '{23, 15, 23, 59};
        logic [7:0] exp_h [4] = '{8'h23, 8'h23, 8'h23, 8'h59};
        logic       exp_p [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int r = 0; r < 4; r++) begin
            a_drive(1'b1, 1'b0, 1'b0);
            a_hits(hits[r]);
            a_wait_over($sformatf("hs%0d", r));
            n_checks++; if (new_high_a !== 1'b0) begin n_fail++; $display("FAIL hs%0d_early_pulse: got %b expected 0", r, new_high_a); end
            @(negedge clk);
            n_checks++; if (new_high_a !== exp_p[r]) begin n_fail++; $display("FAIL hs%0d_pulse: got %b expected %b", r, new_high_a, exp_p[r]); end
            n_checks++; if (high_a !== exp_h[r]) begin n_fail++; $display("FAIL hs%0d_high: got %h expected %h", r, high_a, exp_h[r]); end
            @(negedge clk);
            n_checks++; if (new_high_a !== 1'b0) begin n_fail++; $display("FAIL hs%0d_pulse_len: got %b expected 0", r, new_high_a); end
        end
    endtask

    task automatic test_timer();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n_checks++; if (time_b !== 8'h03) begin n_fail++; $display("FAIL tmr_t0: got %h expected 03", time_b); end
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 3) begin
                n_checks++; if (time_b !== 8'h03) begin n_fail++; $display("FAIL tmr_t3: got %h expected 03", time_b); end
            end else if (i == 4) begin
                n_checks++; if (time_b !== 8'h02) begin n_fail++; $display("FAIL tmr_t4: got %h expected 02", time_b); end
            end else if (i == 8) begin
                n_checks++; if (time_b !== 8'h01) begin n_fail++; $display("FAIL tmr_t8: got %h expected 01", time_b); end
            end else if (i == 11) begin
                n_checks++; if (playing_b !== 1'b1) begin n_fail++; $display("FAIL tmr_t11_playing: got %b expected 1", playing_b); end
            end
        end
        hit_b = 1'b1;
        @(negedge clk);
        hit_b = 1'b0;
        n_checks++; if (time_b !== 8'h00) begin n_fail++; $display("FAIL tmr_t12: got %h expected 00", time_b); end
        n_checks++; if (playing_b !== 1'b0) begin n_fail++; $display("FAIL tmr_playing_drop: got %b expected 0", playing_b); end
        n_checks++; if (game_over_b !== 1'b1) begin n_fail++; $display("FAIL tmr_game_over: got %b expected 1", game_over_b); end
        n_checks++; if (score_b !== 8'h01) begin n_fail++; $display("FAIL tmr_final_hit: got %h expected 01", score_b); end
        hit_b = 1'b1;
        @(negedge clk);
        hit_b = 1'b0;
        n_checks++; if (new_high_b !== 1'b1) begin n_fail++; $display("FAIL tmr_new_high: got %b expected 1", new_high_b); end
        n_checks++; if (score_b !== 8'h01) begin n_fail++; $display("FAIL tmr_over_hit: got %h expected 01", score_b); end
        @(negedge clk);
        n_checks++; if (high_b !== 8'h01) begin n_fail++; $display("FAIL tmr_high: got %h expected 01", high_b); end
        n_checks++; if (time_b !== 8'h00) begin n_fail++; $display("FAIL tmr_over_time: got %h expected 00", time_b); end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; hit_a = 1'b0; miss_a = 1'b0;
        start_b = 1'b0; hit_b = 1'b0; miss_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_saturate();
        test_mid_reset();
        test_high_score();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Game-round controller and BCD score counter that produces the packed two-digit BCD score consumed by the two-digit 7-segment display driver. It takes single-cycle hit/miss events from the mole/button logic and runs a timed round from a 1 kHz tick. It also tracks a session high score. All outputs are registered and ready to wire straight into the display stage.

Parameters:
TICKS_PER_SEC, 1000, clk_1k cycles per round-timer second (≥2)
ROUND_SECS, 30, round length in seconds, integer 1..99, loaded as BCD

Ports:
clk_1k  in  1  1 kHz system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: begin/restart a round
hit  in  1  single-cycle pulse: mole hit
miss  in  1  single-cycle pulse: miss/penalty
score  out  8  packed BCD score {tens,ones}, feeds display score input
time_left  out  8  packed BCD seconds remaining
high_score  out  8  packed BCD best score since reset
playing  out  1  high while in PLAY
game_over  out  1  high while in OVER
new_high  out  1  single-cycle pulse when high_score is updated

Behaviour:
- Reset (sync, on clk_1k edge with rst=1): state IDLE; score=8'h00, time_left=BCD(ROUND_SECS), high_score=8'h00, playing=0, game_over=0, new_high=0, prescaler=0. rst overrides all other inputs, including mid-round.
- States: IDLE, PLAY, OVER. Encoding is 2 bits.
- IDLE: outputs held. start → PLAY.
- Entering PLAY from IDLE or OVER (edge where start=1): score←00, time_left←BCD(ROUND_SECS), prescaler←0. hit/miss on that same edge are ignored.
- PLAY, score update (1-cycle latency, visible the edge after the pulse):
  - hit only: BCD +1 with digit carry (x9→(x+1)0). Saturates at 99.
  - miss only: BCD −1 with borrow ((x)0→(x−1)9). Floors at 00.
  - hit and miss in the same cycle: no change.
  - Digits never leave 0..9.
- PLAY, timer: prescaler counts 0..TICKS_PER_SEC−1. On its wrap edge, time_left decrements in BCD.
- Round end: on the wrap edge where time_left is 01, time_left←00 and state←OVER. A hit/miss on that same edge is still applied to score.
- start during PLAY is ignored.
- OVER:
  - Score is frozen; hit/miss are ignored.
  - On the first cycle in OVER, if score > high_score (unsigned 8-bit compare, valid for packed BCD), then high_score←score and new_high pulses for exactly one cycle. Equal scores do not update.
  - start → PLAY (new round). high_score is retained.
- playing=1 iff state==PLAY. game_over=1 iff state==OVER. Both are registered, and change on the same edge as the state.

Decomposition:
- Shared package score_pkg:
  - state encodings ST_IDLE/ST_PLAY/ST_OVER
  - BCD_ZERO=8'h00, BCD_MAX=8'h99
  - a function converting an integer 0..99 to packed BCD, used for the ROUND_SECS load
- One sub-module, bcd2_counter: two-digit BCD register with sync load, inc, dec, saturate-at-99 and floor-at-00. Inc and dec together means hold.
  - Instantiated twice: once for score, once for time_left (dec only).

Test Plan:
- Reset → score=8'h00, time_left=8'h30, high_score=8'h00, playing=0, game_over=0. Hold rst for 3 cycles with hits pulsing: no change.
- start, then 23 hit pulses → score=8'h23. Check the 8'h09→8'h10 and 8'h19→8'h20 carries. Then 4 misses → 8'h19.
- Saturation and simultaneity:
  - at 99, one hit → stays 8'h99
  - at 00, one miss → stays 8'h00
  - at 8'h45, hit and miss together → stays 8'h45
- Timer with TICKS_PER_SEC=4, ROUND_SECS=3:
  - time_left reads 03, 02, 01, 00 at 4-cycle spacing.
  - playing drops and game_over rises 12 cycles after start.
  - A hit on the final edge is counted; later hits are ignored.
- High score:
  - round 1 ends at 23 → high_score=8'h23, new_high pulses 1 cycle
  - round 2 ends at 15 → high_score stays 8'h23, no pulse
  - round 3 ends at 23 → no pulse (equal)
  - round 4 ends at 59 → high_score=8'h59, pulse
- rst asserted mid-PLAY with score 8'h12 and high_score 8'h40 → next edge gives state IDLE, score=00, high_score=00, time_left=BCD(ROUND_SECS).
